// File: rtl/scp_pkg.sv
// Shared types and helpers for the single-cycle data memory.
// Holds the datapath width default, the load/store width codes and the alignment helpers.
package scp_pkg;

    localparam int SCP_X_LEN = 32;

    // Load/store width codes as they appear in instr[14:12].
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_width_e;

    // Halves must sit on even addresses and words on multiples of four.
    // Byte accesses and unknown codes are never misaligned.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] offset);
        case (func3)
            MEM_H, MEM_HU: return offset[0];
            MEM_W:         return offset != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

    // Forces the natural alignment of an access by dropping the offending low bits.
    function automatic logic [1:0] align_offset(input logic [2:0] func3, input logic [1:0] offset);
        case (func3)
            MEM_H, MEM_HU: return {offset[1], 1'b0};
            MEM_W:         return 2'b00;
            default:       return offset;
        endcase
    endfunction

endpackage

// File: rtl/scp_store_lane.sv
// Store steering: turns a store width code and byte offset into byte enables
// and lane-replicated write data. store_ok is low for codes that are not stores.
module scp_store_lane
    import scp_pkg::*;
#(
    parameter int X_LEN = SCP_X_LEN
) (
    input  logic [2:0]         func3,
    input  logic [1:0]         offset,
    input  logic [X_LEN-1:0]   wdata,
    output logic               store_ok,
    output logic [X_LEN/8-1:0] byte_en,
    output logic [X_LEN-1:0]   lane_data
);

    localparam int NB = X_LEN / 8;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        store_ok  = 1'b0;
        byte_en   = '0;
        lane_data = wdata;
        case (func3)
            MEM_B: begin
                store_ok        = 1'b1;
                byte_en[offset] = 1'b1;
                lane_data       = {NB{wdata[7:0]}};
            end
            MEM_H: begin
                store_ok                      = 1'b1;
                byte_en[{offset[1], 1'b0}]    = 1'b1;
                byte_en[{offset[1], 1'b1}]    = 1'b1;
                lane_data                     = {(NB / 2){wdata[15:0]}};
            end
            MEM_W: begin
                store_ok = 1'b1;
                byte_en  = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/scp_data_mem.sv
// Single-cycle data memory: combinational loads with extension, clocked byte-enabled stores.
// Define SCP_MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
module scp_data_mem
    import scp_pkg::*;
#(
    parameter int X_LEN       = SCP_X_LEN,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [X_LEN-1:0] addr_i,
    input  logic [X_LEN-1:0] wdata_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [2:0]       func3_i,
    output logic [X_LEN-1:0] rdata_o,
    output logic             misalign_o,
    output logic             err_sticky_o,
    output logic [X_LEN-1:0] store_cnt_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = X_LEN / 8;

    logic [X_LEN-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]    word_idx;
    logic [1:0]       offset;
    logic             access_ok;
    logic [X_LEN-1:0] cur_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic             store_ok;
    logic [NB-1:0]    byte_en;
    logic [X_LEN-1:0] lane_data;
    logic             commit;
    logic [X_LEN-1:0] store_cnt_q;
    logic             unused_addr_hi;

    // Upper address bits fall off the end so addresses wrap around the array.
    assign word_idx       = addr_i[AW+1:2];
    assign unused_addr_hi = ^addr_i[X_LEN-1:AW+2];

`ifdef SCP_MISALIGN_TRAP_EN
    logic misaligned;
    logic err_sticky_q;

    assign misaligned = is_misaligned(func3_i, addr_i[1:0]);
    assign offset     = addr_i[1:0];
    assign access_ok  = !misaligned;
    assign misalign_o = !rst_i && (we_i || re_i) && misaligned;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_sticky_q <= 1'b0;
        else if (misalign_o)
            err_sticky_q <= 1'b1;
    end

    assign err_sticky_o = err_sticky_q;
`else
    assign offset       = align_offset(func3_i, addr_i[1:0]);
    assign access_ok    = 1'b1;
    assign misalign_o   = 1'b0;
    assign err_sticky_o = 1'b0;
`endif

    // Reads see the array before this cycle's store lands.
    assign cur_word = mem[word_idx];
    assign byte_sel = cur_word[{offset, 3'b000} +: 8];
    assign half_sel = cur_word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = '0;
        if (!rst_i && re_i && access_ok) begin
            case (func3_i)
                MEM_B:   rdata_o = {{(X_LEN - 8){byte_sel[7]}}, byte_sel};
                MEM_H:   rdata_o = {{(X_LEN - 16){half_sel[15]}}, half_sel};
                MEM_W:   rdata_o = cur_word;
                MEM_BU:  rdata_o = {{(X_LEN - 8){1'b0}}, byte_sel};
                MEM_HU:  rdata_o = {{(X_LEN - 16){1'b0}}, half_sel};
                default: rdata_o = '0;
            endcase
        end
    end

    scp_store_lane #(
        .X_LEN(X_LEN)
    ) u_store_lane (
        .func3    (func3_i),
        .offset   (offset),
        .wdata    (wdata_i),
        .store_ok (store_ok),
        .byte_en  (byte_en),
        .lane_data(lane_data)
    );

    assign commit = we_i && store_ok && access_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the array is cleared asynchronously, which forces a flop array rather than a RAM macro.
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= '0;
            store_cnt_q <= '0;
        end else if (commit) begin
            for (int b = 0; b < NB; b++)
                if (byte_en[b])
                    mem[word_idx][b*8 +: 8] <= lane_data[b*8 +: 8];
            store_cnt_q <= store_cnt_q + X_LEN'(1);
        end
    end

    assign store_cnt_o = store_cnt_q;

endmodule

// File: tb/tb_scp_data_mem.sv
// Directed bench for scp_data_mem with a byte-addressed reference model checked every cycle.
// Honours SCP_MISALIGN_TRAP_EN the same way the design does.
module tb_scp_data_mem;

    localparam int X_LEN       = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam int MEM_BYTES   = DEPTH_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        misalign;
    logic        sticky;
    logic [31:0] store_cnt;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Reference model: flat byte memory plus counters.
    logic [7:0]  mb [MEM_BYTES];
    logic [31:0] m_cnt;
    logic        m_sticky;

    always #5 clk = ~clk;

    scp_data_mem #(
        .X_LEN      (X_LEN),
        .DEPTH_WORDS(DEPTH_WORDS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .we_i        (we),
        .re_i        (re),
        .func3_i     (f3),
        .rdata_o     (rdata),
        .misalign_o  (misalign),
        .err_sticky_o(sticky),
        .store_cnt_o (store_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [2:0] code);
        case (code)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit off_natural(input logic [31:0] a, input logic [2:0] code);
        int s = acc_size(code);
        return (s > 1) && ((a % s) != 0);
    endfunction

    function automatic logic exp_misalign();
`ifdef SCP_MISALIGN_TRAP_EN
        return !rst && (we || re) && off_natural(addr, f3);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_rdata();
        int s = acc_size(f3);
        int unsigned a;
        logic [31:0] v = '0;
        if (rst || !re || s == 0) return '0;
        a = addr % MEM_BYTES;
        if (a % s != 0) begin
`ifdef SCP_MISALIGN_TRAP_EN
            return '0;
`else
            a = a - a % s;
`endif
        end
        for (int i = 0; i < s; i++)
            v = v | (32'(mb[a + i]) << (8 * i));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_edge();
        int s;
        int unsigned a;
        s = acc_size(f3);
        if (rst) return;
        if (exp_misalign()) m_sticky <= 1'b1;
        if (we && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)) begin
            a = addr % MEM_BYTES;
            if (a % s != 0) begin
`ifdef SCP_MISALIGN_TRAP_EN
                return;
`else
                a = a - a % s;
`endif
            end
            for (int i = 0; i < s; i++)
                mb[a + i] <= wdata[8*i +: 8];
            m_cnt <= m_cnt + 32'd1;
        end
    endtask

    always @(posedge rst) begin
        for (int i = 0; i < MEM_BYTES; i++)
            mb[i] <= 8'h00;
        m_cnt    <= '0;
        m_sticky <= 1'b0;
    end

    always @(posedge clk) model_edge();

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_rdata",     rdata,     exp_rdata());
            check("cyc_misalign",  {31'b0, misalign}, {31'b0, exp_misalign()});
            check("cyc_sticky",    {31'b0, sticky},   {31'b0, m_sticky});
            check("cyc_store_cnt", store_cnt, m_cnt);
        end
    end

    task automatic drive(input logic w, input logic r, input logic [2:0] code,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        we = w; re = r; f3 = code; addr = a; wdata = d;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        we = 1'b1; re = 1'b1; f3 = 3'b010; addr = 32'h1; wdata = 32'h5555_5555;
        #1 rst = 1'b1;
        #1;
        check("rst_cnt",      store_cnt, 32'h0);
        check("rst_sticky",   {31'b0, sticky},   32'h0);
        check("rst_rdata",    rdata,     32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0; addr = 32'h0;
        rst = 1'b0;
        cmp_en = 1'b1;

        // Basic word store then load
        drive(1, 0, 3'b010, 32'h10, 32'hDEAD_BEEF);
        drive(0, 1, 3'b010, 32'h10, 32'h0);
        check("lw_10", rdata, 32'hDEAD_BEEF);
        check("cnt_1", store_cnt, 32'd1);

        // Extension cases on word 0x20
        drive(1, 0, 3'b010, 32'h20, 32'h80FF_7F01);
        drive(0, 1, 3'b000, 32'h23, 32'h0);
        check("lb_23", rdata, 32'hFFFF_FF80);
        drive(0, 1, 3'b100, 32'h23, 32'h0);
        check("lbu_23", rdata, 32'h0000_0080);
        drive(0, 1, 3'b001, 32'h22, 32'h0);
        check("lh_22", rdata, 32'hFFFF_80FF);
        drive(0, 1, 3'b101, 32'h20, 32'h0);
        check("lhu_20", rdata, 32'h0000_7F01);

        // Byte store merges into existing word
        drive(1, 0, 3'b010, 32'h30, 32'h1122_3344);
        drive(1, 0, 3'b000, 32'h31, 32'h0000_00AA);
        drive(0, 1, 3'b010, 32'h30, 32'h0);
        check("sb_merge", rdata, 32'h1122_AA44);
        check("cnt_4", store_cnt, 32'd4);

        // Misaligned word store
        drive(1, 0, 3'b010, 32'h41, 32'h1234_5678);
`ifdef SCP_MISALIGN_TRAP_EN
        check("mis_same_cycle", {31'b0, misalign}, 32'h1);
        drive(0, 1, 3'b010, 32'h40, 32'h0);
        check("mis_no_write", rdata, 32'h0);
        check("mis_sticky", {31'b0, sticky}, 32'h1);
        check("mis_cnt", store_cnt, 32'd4);
`else
        check("mis_flag_off", {31'b0, misalign}, 32'h0);
        drive(0, 1, 3'b010, 32'h40, 32'h0);
        check("mis_aligned_write", rdata, 32'h1234_5678);
        check("mis_sticky_off", {31'b0, sticky}, 32'h0);
        check("mis_cnt", store_cnt, 32'd5);
`endif

        // Misaligned half load
        drive(0, 1, 3'b001, 32'h23, 32'h0);
`ifdef SCP_MISALIGN_TRAP_EN
        check("lh_23_trap", rdata, 32'h0);
`else
        check("lh_23_align", rdata, 32'hFFFF_80FF);
`endif

        // Unknown codes: load returns 0, store neither writes nor counts
        drive(0, 1, 3'b011, 32'h10, 32'h0);
        check("load_bad_code", rdata, 32'h0);
        drive(1, 0, 3'b011, 32'h10, 32'h0);
        drive(0, 1, 3'b010, 32'h10, 32'h0);
        check("store_bad_code", rdata, 32'hDEAD_BEEF);

        // Address wrap
        drive(1, 0, 3'b010, MEM_BYTES + 32'h8, 32'hCAFE_F00D);
        drive(0, 1, 3'b010, 32'h8, 32'h0);
        check("alias_8", rdata, 32'hCAFE_F00D);

        // Same-cycle read and write
        drive(1, 0, 3'b010, 32'h50, 32'h1111_1111);
        drive(1, 1, 3'b010, 32'h50, 32'h2222_2222);
        check("rw_old", rdata, 32'h1111_1111);
        drive(0, 1, 3'b010, 32'h50, 32'h0);
        check("rw_new", rdata, 32'h2222_2222);

        // Reset arriving between edges while a store is pending
        drive(1, 0, 3'b010, 32'h60, 32'h0000_0099);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cnt",    store_cnt, 32'h0);
        check("mid_rst_sticky", {31'b0, sticky}, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b1; f3 = 3'b010; addr = 32'h60;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_dropped", rdata, 32'h0);
        drive(0, 1, 3'b010, 32'h10, 32'h0);
        check("mid_rst_clear_10", rdata, 32'h0);
        check("mid_rst_cnt_after", store_cnt, 32'h0);

        drive(0, 0, 3'b000, 32'h0, 32'h0);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
